// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider.
// One quotient bit is resolved per clock, MSB first. A zero divisor is
// flagged without entering the iterative loop and reports its result one
// edge after acceptance.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state, state_n;

    // Working registers: partial remainder, shifting dividend/quotient, divisor, step counter
    logic [WIDTH-1:0] r_q, r_n;
    logic [WIDTH-1:0] q_q, q_n;
    logic [WIDTH-1:0] d_q, d_n;
    logic [CW-1:0]    cnt_q, cnt_n;

    // Zero-divisor result pending for the edge after acceptance
    logic             pend_q, pend_n;
    logic [WIDTH-1:0] pdiv_q, pdiv_n;

    // Next values of the registered outputs
    logic             busy_n, done_n, dbz_n;
    logic [WIDTH-1:0] quot_n, rem_n;

    // One restoring step; the shifted remainder keeps WIDTH+1 bits so a
    // divisor near 2^WIDTH-1 cannot overflow the trial subtraction.
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   diff_c;
    logic             ge_c;
    logic [WIDTH-1:0] r_step_c;
    logic [WIDTH-1:0] q_step_c;

    assign shifted_c = {r_q, q_q[WIDTH-1]};
    assign diff_c    = shifted_c - {1'b0, d_q};
    assign ge_c      = (shifted_c >= {1'b0, d_q});
    // Either choice is below the divisor, so the top bit is always zero
    assign r_step_c  = ge_c ? WIDTH'(diff_c) : WIDTH'(shifted_c);
    assign q_step_c  = {q_q[WIDTH-2:0], ge_c};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start && (divisor != '0)) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath and output next-value logic
    always_comb begin
        r_n    = r_q;
        q_n    = q_q;
        d_n    = d_q;
        cnt_n  = cnt_q;
        pend_n = 1'b0;
        pdiv_n = pdiv_q;
        busy_n = busy;
        done_n = 1'b0;
        quot_n = quotient;
        rem_n  = remainder;
        dbz_n  = div_by_zero;

        // A zero-divisor request accepted last edge reports now
        if (pend_q) begin
            done_n = 1'b1;
            quot_n = '1;
            rem_n  = pdiv_q;
            dbz_n  = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        r_n    = '0;
                        q_n    = dividend;
                        d_n    = divisor;
                        cnt_n  = CW'(WIDTH - 1);
                        busy_n = 1'b1;
                    end else begin
                        pend_n = 1'b1;
                        pdiv_n = dividend;
                    end
                end
            end
            S_RUN: begin
                r_n = r_step_c;
                q_n = q_step_c;
                if (cnt_q == '0) begin
                    quot_n = q_step_c;
                    rem_n  = r_step_c;
                    dbz_n  = 1'b0;
                    done_n = 1'b1;
                    busy_n = 1'b0;
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pdiv_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            r_q         <= r_n;
            q_q         <= q_n;
            d_q         <= d_n;
            cnt_q       <= cnt_n;
            pend_q      <= pend_n;
            pdiv_q      <= pdiv_n;
            busy        <= busy_n;
            done        <= done_n;
            quotient    <= quot_n;
            remainder   <= rem_n;
            div_by_zero <= dbz_n;
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=8) plus an identity sweep.
module tb_seq_restoring_divider;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present a request for one edge; returns #1 after the accepting edge
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
    endtask

    // Wait (bounded) for done; reports edges waited and busy cycles seen
    task automatic wait_done(output int lat, output int busy_cycles);
        bit found;
        found       = 1'b0;
        lat         = 0;
        busy_cycles = busy ? 1 : 0;
        while (!found && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) found = 1'b1;
            else if (busy) busy_cycles++;
        end
        if (!found) chk("done_timeout", 32'(found), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] eq,
                                input logic [WIDTH-1:0] er, input logic edbz);
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    endtask

    // Count done pulses over a window of edges
    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int pulses;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1 rst = 1'b1;
        #5;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        check_result("reset", 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 200/7 with latency and busy-length checks
        start_op(8'd200, 8'd7);
        chk("t1_busy_after_accept", 32'(busy), 32'd1);
        wait_done(lat, bc);
        chk("t1_latency", 32'(lat), 32'd8);
        chk("t1_busy_cycles", 32'(bc), 32'd8);
        chk("t1_busy_at_done", 32'(busy), 32'd0);
        check_result("t1", 8'd28, 8'd4, 1'b0);
        @(posedge clk);
        #1;
        chk("t1_done_one_cycle", 32'(done), 32'd0);
        check_result("t1_hold", 8'd28, 8'd4, 1'b0);

        // Boundary operands
        start_op(8'd255, 8'd1);
        wait_done(lat, bc);
        check_result("t2a", 8'd255, 8'd0, 1'b0);
        start_op(8'd5, 8'd9);
        wait_done(lat, bc);
        check_result("t2b", 8'd0, 8'd5, 1'b0);
        start_op(8'd255, 8'd255);
        wait_done(lat, bc);
        check_result("t2c", 8'd1, 8'd0, 1'b0);

        // Divide by zero
        start_op(8'd100, 8'd0);
        chk("t3_busy_after_accept", 32'(busy), 32'd0);
        wait_done(lat, bc);
        chk("t3_latency", 32'(lat), 32'd1);
        chk("t3_busy_cycles", 32'(bc), 32'd0);
        check_result("t3", 8'd255, 8'd100, 1'b1);
        @(posedge clk);
        #1;
        chk("t3_done_one_cycle", 32'(done), 32'd0);

        // Start while busy is ignored
        start_op(8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        start_op(8'd10, 8'd3);
        wait_done(lat, bc);
        chk("t4_latency", 32'(lat), 32'd4);
        check_result("t4", 8'd28, 8'd4, 1'b0);
        count_done(12, pulses);
        chk("t4_extra_done", 32'(pulses), 32'd0);

        // Asynchronous reset mid-division
        start_op(8'd200, 8'd7);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_busy_async", 32'(busy), 32'd0);
        chk("t5_done_async", 32'(done), 32'd0);
        check_result("t5_async", 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        count_done(12, pulses);
        chk("t5_no_done", 32'(pulses), 32'd0);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        start_op(8'd9, 8'd2);
        wait_done(lat, bc);
        chk("t5_latency", 32'(lat), 32'd8);
        check_result("t5", 8'd4, 8'd1, 1'b0);

        // Back-to-back: new start in the done cycle
        @(posedge clk);
        #1;
        start_op(8'd13, 8'd4);
        wait_done(lat, bc);
        check_result("t6a", 8'd3, 8'd1, 1'b0);
        start_op(8'd50, 8'd6);
        chk("t6_done_drops", 32'(done), 32'd0);
        chk("t6_busy_again", 32'(busy), 32'd1);
        check_result("t6a_hold", 8'd3, 8'd1, 1'b0);
        wait_done(lat, bc);
        chk("t6b_latency", 32'(lat), 32'd8);
        check_result("t6b", 8'd8, 8'd2, 1'b0);

        // Random sweep against the division identities
        for (int i = 0; i < 2000; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom_range(1, 255));
            start_op(a, b);
            wait_done(lat, bc);
            chk("sweep_q", 32'(quotient), 32'(a / b));
            chk("sweep_r", 32'(remainder), 32'(a % b));
            chk("sweep_ident", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
